// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester ports, the pipeline status outputs and the data
// memory bus of dmem_arbiter.
//   slave  : the arbiter's view (requests and mem_rdata in, everything else out)
//   master : the environment's view (requesters plus data memory)
// Port summary:
//   p0_* : MEM-stage requester   (req/we/addr/wdata in, rdata/done out)
//   p1_* : loader/DMA requester  (same shape as p0)
//   stall, busy : pipeline status
//   mem_addr/mem_wdata/mem_write/mem_read out, mem_rdata in : data memory bus
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic [DW-1:0] p0_rdata;
    logic          p0_done;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [DW-1:0] p1_rdata;
    logic          p1_done;

    logic          stall;
    logic          busy;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_rdata, p0_done, p1_rdata, p1_done,
        output stall, busy,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_rdata, p0_done, p1_rdata, p1_done,
        input  stall, busy,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data memory between the pipeline MEM stage (port 0) and the
// loader/DMA port (port 1). A winning request is latched in IDLE, the memory
// controls are held for LATENCY cycles in ACCESS, read data is captured on the
// last ACCESS cycle and the winner gets a one-cycle done pulse in RESP.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave (requesters, stall/busy, memory bus)
// Parameters: LATENCY (>=1 access cycles), AW address width, DW data width.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking; without
// it port 0 always wins a tie.
module dmem_arbiter #(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   last_grant_reg, last_grant_next;
    logic                   winner_reg, winner_next;
    logic                   we_reg, we_next;
    logic [AW-1:0]          mem_addr_reg, mem_addr_next;
    logic [DW-1:0]          mem_wdata_reg, mem_wdata_next;
    logic                   mem_read_reg, mem_read_next;
    logic                   mem_write_reg, mem_write_next;
    logic [1:0][DW-1:0]     rdata_reg, rdata_next;

    // Per-port views of the requester inputs, indexed by port number.
    logic [1:0]             req_vec;
    logic [1:0]             we_vec;
    logic [1:0][AW-1:0]     addr_vec;
    logic [1:0][DW-1:0]     wdata_vec;
    logic [1:0]             done_vec;
    logic                   grant_p1;

    assign req_vec   = {bus.p1_req,   bus.p0_req};
    assign we_vec    = {bus.p1_we,    bus.p0_we};
    assign addr_vec  = {bus.p1_addr,  bus.p0_addr};
    assign wdata_vec = {bus.p1_wdata, bus.p0_wdata};

`ifdef DMEM_ARB_RR_EN
    // On a tie, serve the port that was not served last.
    assign grant_p1 = req_vec[1] & (~req_vec[0] | ~last_grant_reg);
`else
    assign grant_p1 = req_vec[1] & ~req_vec[0];
`endif

    // Done is decoded from registered state, so it is a clean one-cycle pulse.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign done_vec[gi] = (state_reg == RESP) && (winner_reg == 1'(gi));
        end
    endgenerate

    assign bus.p0_done   = done_vec[0];
    assign bus.p1_done   = done_vec[1];
    assign bus.p0_rdata  = rdata_reg[0];
    assign bus.p1_rdata  = rdata_reg[1];
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_read  = mem_read_reg;
    assign bus.mem_write = mem_write_reg;
    assign bus.busy      = (state_reg != IDLE);
    // Combinational so the pipeline freezes in the very cycle p0_req rises.
    assign bus.stall     = bus.p0_req & ~done_vec[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            winner_reg     <= 1'b0;
            we_reg         <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            last_grant_reg <= last_grant_next;
            winner_reg     <= winner_next;
            we_reg         <= we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            rdata_reg      <= rdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        last_grant_next = last_grant_reg;
        winner_next     = winner_reg;
        we_next         = we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_read_next   = mem_read_reg;
        mem_write_next  = mem_write_reg;
        rdata_next      = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    winner_next    = grant_p1;
                    we_next        = we_vec[grant_p1];
                    mem_addr_next  = addr_vec[grant_p1];
                    mem_wdata_next = wdata_vec[grant_p1];
                    mem_write_next = we_vec[grant_p1];
                    mem_read_next  = ~we_vec[grant_p1];
                    cnt_next       = CW'(LATENCY - 1);
                    state_next     = ACCESS;
                end else begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_reg == '0) begin
                    // Writes leave the port's rdata untouched.
                    if (!we_reg) begin
                        rdata_next[winner_reg] = bus.mem_rdata;
                    end
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                last_grant_next = winner_reg;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Two arbiter instances share clk/rst: dut_a with LATENCY=1 (single read
// timing test) and dut_b with LATENCY=3 (scoreboarded traffic, ties, stall,
// reset mid-transaction). Expected completions are pushed to sb_q in service
// order and popped when a done pulse appears on dut_b.
module tb_dmem_arbiter;
    localparam int LB = 3;

    logic clk;
    logic rst;

    dmem_arbiter_if #(.AW(32), .DW(32)) a_if ();
    dmem_arbiter_if #(.AW(32), .DW(32)) b_if ();

    dmem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    dmem_arbiter #(.LATENCY(LB), .AW(32), .DW(32)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // dut_a memory: read-only pattern with the preloaded word at 0x10.
    always_comb a_if.mem_rdata = (a_if.mem_addr == 32'h10) ? 32'hDEADBEEF : ~a_if.mem_addr;

    // dut_b memory: word array with combinational read, written while mem_write.
    logic [31:0] mem_b   [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ref_rd  [2];

    always_comb b_if.mem_rdata = mem_b[b_if.mem_addr[9:2]];

    always @(posedge clk) begin
        if (b_if.mem_write) mem_b[b_if.mem_addr[9:2]] <= b_if.mem_wdata;
    end

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    task automatic expect_txn(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        exp_t e;
        if (we) ref_mem[addr[9:2]] = wdata;
        else    ref_rd[port] = ref_mem[addr[9:2]];
        e.port  = port;
        e.rdata = ref_rd[port];
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (b_if.p0_done || b_if.p1_done) begin
            if (sb_q.size() == 0) begin
                check("sb_spurious_done", {30'b0, b_if.p1_done, b_if.p0_done}, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_port", {31'b0, b_if.p1_done}, {31'b0, e.port});
                check("sb_one_done", {31'b0, b_if.p0_done & b_if.p1_done}, 32'h0);
                check("sb_rdata", e.port ? b_if.p1_rdata : b_if.p0_rdata, e.rdata);
                $display("txn port=%0d rdata=%h exp=%h", e.port,
                         e.port ? b_if.p1_rdata : b_if.p0_rdata, e.rdata);
            end
        end
    end

    // Drives one request on dut_b and waits for its done. With chk set the
    // arbiter is expected to be idle at the call, so control cycles and
    // latency are checked exactly.
    task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit chk, output int lat);
        int ctrl;
        bit seen;
        if (port) begin
            b_if.p1_we = we; b_if.p1_addr = addr; b_if.p1_wdata = wdata; b_if.p1_req = 1'b1;
        end else begin
            b_if.p0_we = we; b_if.p0_addr = addr; b_if.p0_wdata = wdata; b_if.p0_req = 1'b1;
        end
        ctrl = 0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(posedge clk); #1;
            if (chk && (b_if.mem_read || b_if.mem_write)) begin
                ctrl++;
                check("ctrl_addr", b_if.mem_addr, addr);
                check("ctrl_write", {31'b0, b_if.mem_write}, {31'b0, we});
                check("ctrl_read", {31'b0, b_if.mem_read}, {31'b0, ~we});
                if (we) check("ctrl_wdata", b_if.mem_wdata, wdata);
            end
            if (port ? b_if.p1_done : b_if.p0_done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) check("done_timeout", 32'h0, 32'h1);
        if (chk) begin
            check("ctrl_cycles", ctrl, LB);
            check("latency", lat, LB + 1);
        end
        @(posedge clk); #1;
        if (port) b_if.p1_req = 1'b0;
        else      b_if.p0_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int i1;
        int i0;

        rst = 1'b1;
        a_if.p0_req = 0; a_if.p0_we = 0; a_if.p0_addr = 0; a_if.p0_wdata = 0;
        a_if.p1_req = 0; a_if.p1_we = 0; a_if.p1_addr = 0; a_if.p1_wdata = 0;
        b_if.p0_req = 0; b_if.p0_we = 0; b_if.p0_addr = 0; b_if.p0_wdata = 0;
        b_if.p1_req = 0; b_if.p1_we = 0; b_if.p1_addr = 0; b_if.p1_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem_b[i]   <= 32'hC0DE0000 | i;
            ref_mem[i]  = 32'hC0DE0000 | i;
        end
        mem_b[4]   <= 32'hDEADBEEF;
        ref_mem[4]  = 32'hDEADBEEF;
        ref_rd[0]   = 32'h0;
        ref_rd[1]   = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, b_if.busy}, 32'h0);
        check("rst_mem_read", {31'b0, b_if.mem_read}, 32'h0);
        check("rst_mem_write", {31'b0, b_if.mem_write}, 32'h0);
        check("rst_mem_addr", b_if.mem_addr, 32'h0);
        check("rst_dones", {30'b0, b_if.p1_done, b_if.p0_done}, 32'h0);
        check("rst_rdata0", b_if.p0_rdata, 32'h0);
        check("rst_stall", {31'b0, b_if.stall}, 32'h0);
        check("rst_a_busy", {31'b0, a_if.busy}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // LATENCY=1 read of 0x10 on dut_a.
        a_if.p0_we = 1'b0; a_if.p0_addr = 32'h10; a_if.p0_req = 1'b1;
        #1;
        check("a_stall_same_cycle", {31'b0, a_if.stall}, 32'h1);
        @(posedge clk); #1;
        check("a_busy", {31'b0, a_if.busy}, 32'h1);
        check("a_mem_read", {31'b0, a_if.mem_read}, 32'h1);
        check("a_mem_addr", a_if.mem_addr, 32'h10);
        check("a_done_early", {31'b0, a_if.p0_done}, 32'h0);
        check("a_stall_access", {31'b0, a_if.stall}, 32'h1);
        @(posedge clk); #1;
        check("a_mem_read_off", {31'b0, a_if.mem_read}, 32'h0);
        check("a_done", {31'b0, a_if.p0_done}, 32'h1);
        check("a_rdata", a_if.p0_rdata, 32'hDEADBEEF);
        check("a_stall_release", {31'b0, a_if.stall}, 32'h0);
        check("a_p1_done", {31'b0, a_if.p1_done}, 32'h0);
        a_if.p0_req = 1'b0;
        @(posedge clk); #1;
        check("a_done_pulse", {31'b0, a_if.p0_done}, 32'h0);
        check("a_idle", {31'b0, a_if.busy}, 32'h0);
        check("a_rdata_hold", a_if.p0_rdata, 32'hDEADBEEF);

        // p1 write then read back on dut_b (LATENCY=3).
        expect_txn(1'b1, 1'b1, 32'h20, 32'h12345678);
        issue(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1, lat);
        expect_txn(1'b1, 1'b0, 32'h20, 32'h0);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, lat);

        // Simultaneous requests, each port issuing two back-to-back reads.
`ifdef DMEM_ARB_RR_EN
        expect_txn(1'b0, 1'b0, 32'h40, 32'h0);
        expect_txn(1'b1, 1'b0, 32'h80, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h44, 32'h0);
        expect_txn(1'b1, 1'b0, 32'h84, 32'h0);
`else
        expect_txn(1'b0, 1'b0, 32'h40, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h44, 32'h0);
        expect_txn(1'b1, 1'b0, 32'h80, 32'h0);
        expect_txn(1'b1, 1'b0, 32'h84, 32'h0);
`endif
        fork
            begin
                int l0;
                issue(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, l0);
                issue(1'b0, 1'b0, 32'h44, 32'h0, 1'b0, l0);
            end
            begin
                int l1;
                issue(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, l1);
                issue(1'b1, 1'b0, 32'h84, 32'h0, 1'b0, l1);
            end
        join
        @(posedge clk); #1;

        // p0 requests while p1 is in ACCESS.
        expect_txn(1'b1, 1'b0, 32'h14, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h18, 32'h0);
        i1 = -1;
        i0 = -1;
        fork
            begin
                int l1;
                issue(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, l1);
            end
            begin
                @(posedge clk); #1;
                check("p1_busy", {31'b0, b_if.busy}, 32'h1);
                b_if.p0_we = 1'b0; b_if.p0_addr = 32'h18; b_if.p0_req = 1'b1;
                #1;
                check("stall_rise", {31'b0, b_if.stall}, 32'h1);
                for (int k = 1; k <= 60 && i0 < 0; k++) begin
                    @(posedge clk); #1;
                    if (b_if.p1_done) i1 = k;
                    if (b_if.p0_done) i0 = k;
                    else check("stall_wait", {31'b0, b_if.stall}, 32'h1);
                end
                if (i0 < 0) check("p0_wait_timeout", 32'h0, 32'h1);
                check("p0_after_p1", i0 - i1, LB + 2);
                check("stall_done_cycle", {31'b0, b_if.stall}, 32'h0);
                @(posedge clk); #1;
                b_if.p0_req = 1'b0;
            end
        join
        @(posedge clk); #1;

        // Reset during the 2nd ACCESS cycle of a p0 write.
        b_if.p0_we = 1'b1; b_if.p0_addr = 32'h30; b_if.p0_wdata = 32'hCAFEF00D; b_if.p0_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mr_write_active", {31'b0, b_if.mem_write}, 32'h1);
        rst = 1'b1;
        b_if.p0_req = 1'b0;
        @(posedge clk); #1;
        check("mr_mem_write", {31'b0, b_if.mem_write}, 32'h0);
        check("mr_busy", {31'b0, b_if.busy}, 32'h0);
        check("mr_p0_done", {31'b0, b_if.p0_done}, 32'h0);
        check("mr_mem_addr", b_if.mem_addr, 32'h0);
        check("mr_mem_wdata", b_if.mem_wdata, 32'h0);
        check("mr_rdata0", b_if.p0_rdata, 32'h0);
        check("mr_rdata1", b_if.p1_rdata, 32'h0);
        check("mr_stall", {31'b0, b_if.stall}, 32'h0);
        rst = 1'b0;
        ref_rd[0] = 32'h0;
        ref_rd[1] = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
            check("mr_no_done", {31'b0, b_if.p0_done}, 32'h0);
        end

        expect_txn(1'b1, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, lat);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data memory between two requesters.
  - Port 0: pipeline MEM stage.
  - Port 1: loader/DMA port, used for program/data preload and debug peek/poke.
- Latches the winning request, holds the memory controls for a fixed access latency, captures read data and returns a one-cycle done pulse.
- Drives a stall to the pipeline while a port-0 access is outstanding.

Parameters:
- LATENCY, 1, memory access cycles per transaction (>=1); controls held for exactly LATENCY cycles.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- p0_req  input  1  MEM-stage access request; held until p0_done.
- p0_we  input  1  1 = write, 0 = read.
- p0_addr  input  AW  byte address (ALU result).
- p0_wdata  input  DW  store data.
- p0_rdata  output  DW  load data; valid when p0_done.
- p0_done  output  1  one-cycle completion pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_done: same as port 0, for port 1.
- stall  output  1  p0_req & ~p0_done (combinational), to the pipeline latches.
- busy  output  1  high in any state other than IDLE.
- mem_addr  output  AW  to data memory.
- mem_wdata  output  DW  to data memory.
- mem_write  output  1  to data memory.
- mem_read  output  1  to data memory.
- mem_rdata  input  DW  from data memory.

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values:
  - All outputs 0; state = IDLE.
  - Counter = 0.
  - last_grant = 1, so port 0 wins the first tie.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high, pick the winner. Fixed priority gives port 0; see Optional Feature.
  - Register the winner's we/addr/wdata into mem_addr/mem_wdata/mem_write/mem_read, set cnt = LATENCY-1 and go to ACCESS.
  - With no req, stay in IDLE; mem_read = mem_write = 0.
- ACCESS:
  - mem_read = ~we and mem_write = we, held every cycle. Address and data are stable throughout.
  - cnt decrements each cycle.
  - On the cycle with cnt == 0:
    - Capture mem_rdata into the winner's rdata register. Capture only on reads; a write leaves rdata unchanged.
    - Clear mem_read and mem_write, and go to RESP.
- RESP:
  - The winner's done = 1 for exactly this cycle; the loser's done stays 0.
  - Update last_grant to the winner, then go to IDLE.
- Latency:
  - req seen in IDLE at edge t.
  - done is high in cycle t+LATENCY+1.
  - Back-to-back accesses have a minimum one-cycle IDLE gap.
- Requester rules:
  - The requester keeps req, we, addr and wdata stable until done.
  - On the edge after done, the requester deasserts req or presents a new request. A high req in the following IDLE is a new transaction.
- rdata holds its value until the next read completes on that port.
- A losing requester keeps req high and is served on the next IDLE. Its done never pulses while it waits.
- Changes to a requester's inputs after grant are ignored; the latched values are used.
- Reset mid-transaction:
  - The access is abandoned; no done pulse is generated.
  - mem_read and mem_write are 0 from the first cycle after the reset edge.
  - The state returns to IDLE.
- busy = (state != IDLE).
- stall is combinational, so the pipeline freezes in the same cycle p0_req rises and releases in the done cycle.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Simultaneous requests in IDLE are granted to the port opposite last_grant (round-robin).
  - A port that has just been served loses the next tie.
- Undefined:
  - Port 0 always wins ties (fixed priority).
  - Port 1 can be starved by continuous MEM-stage traffic.
  - last_grant is still maintained but unused.

Test Plan:
- LATENCY=1, p0 read addr 0x10 with memory preloaded 0xDEADBEEF:
  - mem_read high for 1 cycle.
  - p0_done pulses 2 cycles after req is sampled, with p0_rdata = 0xDEADBEEF.
  - stall is high from req until the done cycle.
- LATENCY=3, p1 write addr 0x20 data 0x12345678:
  - mem_write is high for exactly 3 cycles with stable addr/data, then p1_done pulses.
  - A subsequent p1 read of 0x20 returns 0x12345678.
  - p1_rdata is unchanged by the write.
- p0 and p1 requests rise in the same cycle, macro undefined:
  - p0 is served first, p1 second.
  - Repeat with p0 immediately re-requesting: p0 wins again.
- Same as above with DMEM_ARB_RR_EN defined:
  - First tie goes to p0, second tie to p1, third tie to p0.
  - Done pulses alternate.
- LATENCY=3, rst asserted in the 2nd ACCESS cycle of a p0 write:
  - The next cycle shows mem_write = 0, busy = 0, no p0_done, and all outputs 0.
  - A new p1 read issued after reset completes normally.
- p1 busy in ACCESS while p0_req rises:
  - stall stays high.
  - p0 is granted in the IDLE after p1's RESP.
  - p0_done arrives LATENCY+1 cycles after that grant.
